stencil_output_sink: RTL
========================

// Module: stencil_output_sink
// PURPOSE
// - Receiving end of the accelerator's push-only output stencil stream (write_valid + write word, no backpressure).
// - Buffers words in a FIFO and drains them to a host-side ready/valid port, tagging the last word of the frame.
// - Reports frame completion, overflow and stray post-frame writes; sits between the generated top and the host/DMA.
// PARAMETERS
// - DATA_W       16    width of one stencil word
// - DEPTH        16    FIFO entries; power of two, >= 2
// - TOTAL_WORDS  4096  words per frame; index TOTAL_WORDS-1 is tagged last
// - CNT_W        16    width of word counters; 2**CNT_W > TOTAL_WORDS
// - CHECK_SEED   0     first expected value for the optional checker
// PORTS
// - clk             in   1       single clock, rising edge
// - rst             in   1       asynchronous, active-high reset
// - flush           in   1       synchronous clear; same effect as reset, one cycle
// - in_write_valid  in   1       producer has a word this cycle
// - in_write        in   DATA_W  producer word
// - out_valid       out  1       head of FIFO is available
// - out_ready       in   1       host accepts head this cycle
// - out_data        out  DATA_W  FIFO head word
// - out_last        out  1       head word is frame index TOTAL_WORDS-1
// - done            out  1       whole frame drained to host
// - overflow        out  1       sticky: a word arrived while FIFO full and was dropped
// - extra_write     out  1       sticky: a word arrived in DONE state and was dropped
// - rx_count        out  CNT_W   words accepted into FIFO this frame
// - mismatch_count  out  CNT_W   checker mismatches (see CONFIGURATION)
// BEHAVIOUR
// - Reset/flush values: out_valid=0, out_last=0, done=0, overflow=0, extra_write=0, rx_count=0, mismatch_count=0,
//   FIFO empty, state IDLE; out_data=0 whenever FIFO empty. flush wins over push/pop in the same cycle.
// - States: IDLE -(first accepted push)-> RUN -(pop of word with out_last=1)-> DONE; DONE holds until rst/flush.
// - Push: in_write_valid in IDLE/RUN and FIFO not full -> write word, rx_count+1; word index = rx_count before increment.
// - Full: push while full and no pop same cycle -> word dropped, rx_count unchanged, overflow set.
//   Push+pop same cycle while full -> both succeed, occupancy unchanged.
// - Push in DONE -> dropped, extra_write set. Pushes beyond TOTAL_WORDS in RUN -> dropped, extra_write set.
// - Latency: word pushed in cycle N is visible at out_data/out_valid in cycle N+1 when FIFO was empty (no bypass).
// - Pop: out_valid && out_ready at rising edge -> head removed; out_data/out_last stable while out_valid && !out_ready.
// - out_last is stored per entry (one extra bit), asserted only with frame index TOTAL_WORDS-1.
// - done asserts the cycle after the last word is popped; out_valid=0 in DONE.
// - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits; full = occupancy==DEPTH.
// - Counters saturate at 2**CNT_W-1; never wrap.
// CONFIGURATION
// - SINK_CHECK_EN defined: each accepted word compared with CHECK_SEED + frame index (mod 2**DATA_W);
//   each inequality increments mismatch_count one cycle after the push.
// - SINK_CHECK_EN undefined: no checker logic; mismatch_count tied to 0. All other behaviour identical.
// TESTING
// - rst pulse, then TOTAL_WORDS=8, push 0..7 one per cycle, out_ready=1 -> 8 pops data 0..7, out_last only on 7,
//   done=1 one cycle after pop of 7, overflow=0, rx_count=8.
// - DEPTH=4, out_ready=0, push 6 words -> first 4 held, overflow=1, rx_count=4, out_data=first word stable.
// - FIFO full, out_ready=1 and push same cycle -> pop and push both accepted, occupancy stays 4, overflow stays 0.
// - After done, push one word -> extra_write=1, rx_count unchanged, out_valid stays 0.
// - Mid-frame (3 words queued) assert flush one cycle -> all outputs at reset values next cycle; new frame restarts at index 0.
// - SINK_CHECK_EN, CHECK_SEED=0, push 0,1,5,3 -> mismatch_count=1; without macro -> mismatch_count=0.

Source files
------------

// File: rtl/stencil_output_sink.sv
// stencil_output_sink: terminates the accelerator's push-only stencil output
// stream. Words land in a small FIFO and drain to a host ready/valid port with
// the final frame word tagged by out_last. Frame completion, FIFO overflow and
// stray writes are reported as status outputs.
//
// Optional feature: define SINK_CHECK_EN to enable an in-line checker that
// compares every accepted word against CHECK_SEED + frame index and counts
// mismatches. Without the macro mismatch_count is constant zero.
module stencil_output_sink #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TOTAL_WORDS = 4096,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned CHECK_SEED  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_write_valid,
  input  logic [DATA_W-1:0] in_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              overflow,
  output logic              extra_write,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  mismatch_count
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = AW + 1;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_WORDS - 1);
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(TOTAL_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem      [DEPTH];
  logic              last_mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_after_pop;
  logic [OCC_W-1:0] occ_nxt;

  logic              pop;
  logic              push;
  logic              push_last;
  logic              full;
  logic              frame_full;
  logic              drop_extra;
  logic              drop_ovf;
  logic              out_valid_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic              out_last_nxt;

  // Push/pop arbitration, next FIFO pointers and the next registered head word
  always_comb begin
    pop        = out_valid && out_ready;
    full       = (occ == OCC_FULL);
    frame_full = (rx_count >= TOTAL);
    push       = 1'b0;
    drop_extra = 1'b0;
    drop_ovf   = 1'b0;
    if (in_write_valid) begin
      if (state == S_DONE || frame_full) begin
        drop_extra = 1'b1;
      end else if (full && !pop) begin
        drop_ovf = 1'b1;
      end else begin
        push = 1'b1;
      end
    end

    push_last     = (rx_count == LAST_IDX);
    occ_after_pop = occ - OCC_W'(pop);
    occ_nxt       = occ_after_pop + OCC_W'(push);
    rd_nxt        = rd_ptr + AW'(pop);

    // Head comes straight from the incoming word only when it lands in an
    // otherwise empty FIFO; this keeps out_data registered without a bypass.
    out_valid_nxt = (occ_nxt != '0);
    out_data_nxt  = '0;
    out_last_nxt  = 1'b0;
    if (occ_nxt != '0) begin
      if (push && occ_after_pop == '0) begin
        out_data_nxt = in_write;
        out_last_nxt = push_last;
      end else begin
        out_data_nxt = mem[rd_nxt];
        out_last_nxt = last_mem[rd_nxt];
      end
    end

    state_nxt = state;
    case (state)
      S_IDLE:  if (push) state_nxt = S_RUN;
      S_RUN:   if (pop && out_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_DONE && pop && out_last) state_nxt = S_DONE;
  end

  // FIFO storage; pointers are cleared on reset/flush so stale data is unreachable
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= in_write;
      last_mem[wr_ptr] <= push_last;
    end
  end

  // Control state, pointers, registered host port and sticky status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      extra_write <= 1'b0;
      rx_count    <= '0;
    end else if (flush) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      extra_write <= 1'b0;
      rx_count    <= '0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr + AW'(push);
      rd_ptr      <= rd_nxt;
      occ         <= occ_nxt;
      out_valid   <= out_valid_nxt;
      out_data    <= out_data_nxt;
      out_last    <= out_last_nxt;
      done        <= (state_nxt == S_DONE);
      overflow    <= overflow | drop_ovf;
      extra_write <= extra_write | drop_extra;
      if (push && rx_count != CNT_MAX) begin
        rx_count <= rx_count + CNT_W'(1);
      end
    end
  end

`ifdef SINK_CHECK_EN
  logic [DATA_W-1:0] exp_word;

  assign exp_word = DATA_W'(CHECK_SEED) + DATA_W'(rx_count);

  // Count accepted words that differ from the expected ramp, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_count <= '0;
    end else if (flush) begin
      mismatch_count <= '0;
    end else if (push && in_write != exp_word && mismatch_count != CNT_MAX) begin
      mismatch_count <= mismatch_count + CNT_W'(1);
    end
  end
`else
  logic unused_seed;

  assign unused_seed    = ^DATA_W'(CHECK_SEED);
  assign mismatch_count = '0;
`endif

endmodule
